pll_reconfig_ctrl: RTL and testbench

Sequencer that retunes the fractional PLL at run time through the PLL reconfiguration core's Avalon-MM management port. It does the following:
- Latches a requested configuration (M counter, C0 counter, fractional K).
- Writes the configuration registers in a fixed order, then triggers the reconfiguration.
- Waits for the PLL to report a stable lock.
- Reports done or error to the core.

It sits between core logic (e.g. a video-mode or memory-speed selector) and the reconfig core attached to the PLL's reconfig_to_pll/reconfig_from_pll buses.

---
 rtl/pll_reconfig_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_pll_reconfig_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer: latches an M/C/K request, programs the reconfig core over
// Avalon-MM in a fixed order, then waits for a stable lock before reporting done or a timeout.
module pll_reconfig_ctrl #(
  parameter int TIMEOUT_CYCLES = 1048575,
  parameter int LOCK_STABLE    = 1024,
  parameter int C_SEL          = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [7:0]  cfg_m_hi,
  input  logic [7:0]  cfg_m_lo,
  input  logic        cfg_m_odd,
  input  logic [7:0]  cfg_c_hi,
  input  logic [7:0]  cfg_c_lo,
  input  logic        cfg_c_odd,
  input  logic [31:0] cfg_k,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int STAB_W = $clog2(LOCK_STABLE + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [STAB_W-1:0] STAB_LAST  = STAB_W'(LOCK_STABLE - 1);
  localparam logic [4:0]        C_SEL_BITS = 5'(C_SEL);

  localparam logic [5:0] ADDR_MODE  = 6'h00;
  localparam logic [5:0] ADDR_M     = 6'h04;
  localparam logic [5:0] ADDR_C     = 6'h05;
  localparam logic [5:0] ADDR_K     = 6'h07;
  localparam logic [5:0] ADDR_START = 6'h02;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_MODE   = 3'd1,
    WR_M      = 3'd2,
    WR_C      = 3'd3,
    WR_K      = 3'd4,
    WR_START  = 3'd5,
    WAIT_LOCK = 3'd6
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0]  hold_m_hi;
  logic [7:0]  hold_m_lo;
  logic        hold_m_odd;
  logic [7:0]  hold_c_hi;
  logic [7:0]  hold_c_lo;
  logic        hold_c_odd;
  logic [31:0] hold_k;

  logic lock_meta;
  logic lock_sync;

  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_cnt_nxt;
  logic [STAB_W-1:0] stable_cnt;
  logic [STAB_W-1:0] stable_cnt_nxt;

  logic        load;
  logic        in_write;
  logic        accept;
  logic        busy_nxt;
  logic        done_nxt;
  logic        error_nxt;
  logic        write_nxt;
  logic [5:0]  addr_nxt;
  logic [31:0] data_nxt;

  function automatic state_t next_write(input state_t cur);
    state_t nxt;
    case (cur)
      WR_MODE:  nxt = WR_M;
      WR_M:     nxt = WR_C;
      WR_C:     nxt = WR_K;
      WR_K:     nxt = WR_START;
      WR_START: nxt = WAIT_LOCK;
      default:  nxt = IDLE;
    endcase
    return nxt;
  endfunction

  assign in_write = state inside {WR_MODE, WR_M, WR_C, WR_K, WR_START};
  assign accept   = in_write & mgmt_write & ~mgmt_waitrequest;

  // Lock synchronizer; held clear outside WAIT_LOCK so a lock from the old setting is never trusted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else if (state != WAIT_LOCK) begin
      lock_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_sync <= lock_meta;
    end
  end

  // Holding registers for the accepted request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_m_hi  <= 8'd0;
      hold_m_lo  <= 8'd0;
      hold_m_odd <= 1'b0;
      hold_c_hi  <= 8'd0;
      hold_c_lo  <= 8'd0;
      hold_c_odd <= 1'b0;
      hold_k     <= 32'd0;
    end else if (load) begin
      hold_m_hi  <= cfg_m_hi;
      hold_m_lo  <= cfg_m_lo;
      hold_m_odd <= cfg_m_odd;
      hold_c_hi  <= cfg_c_hi;
      hold_c_lo  <= cfg_c_lo;
      hold_c_odd <= cfg_c_odd;
      hold_k     <= cfg_k;
    end
  end

  // Next-state, counters and status.
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    stable_cnt_nxt = stable_cnt;
    busy_nxt       = busy;
    error_nxt      = error;
    done_nxt       = 1'b0;
    load           = 1'b0;
    case (state)
      IDLE: begin
        wait_cnt_nxt   = '0;
        stable_cnt_nxt = '0;
        if (req) begin
          load      = 1'b1;
          busy_nxt  = 1'b1;
          error_nxt = 1'b0;
          state_nxt = WR_MODE;
        end else begin
          state_nxt = IDLE;
        end
      end
      WR_MODE, WR_M, WR_C, WR_K, WR_START: begin
        if (accept) begin
          wait_cnt_nxt   = '0;
          stable_cnt_nxt = '0;
          state_nxt      = next_write(state);
        end else if (wait_cnt == WAIT_LAST) begin
          wait_cnt_nxt = '0;
          error_nxt    = 1'b1;
          busy_nxt     = 1'b0;
          state_nxt    = IDLE;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      WAIT_LOCK: begin
        if (lock_sync && (stable_cnt == STAB_LAST)) begin
          done_nxt       = 1'b1;
          busy_nxt       = 1'b0;
          wait_cnt_nxt   = '0;
          stable_cnt_nxt = '0;
          state_nxt      = IDLE;
        end else begin
          // A lock drop only restarts the stability window.
          stable_cnt_nxt = lock_sync ? (stable_cnt + STAB_W'(1)) : '0;
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt_nxt   = '0;
            stable_cnt_nxt = '0;
            error_nxt      = 1'b1;
            busy_nxt       = 1'b0;
            state_nxt      = IDLE;
          end else begin
            wait_cnt_nxt = wait_cnt + WAIT_W'(1);
          end
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Write bus contents for the state about to be entered, so the strobe appears in its first cycle.
  always_comb begin
    write_nxt = 1'b1;
    addr_nxt  = 6'd0;
    data_nxt  = 32'd0;
    case (state_nxt)
      WR_MODE: begin
        addr_nxt = ADDR_MODE;
        data_nxt = 32'd0;
      end
      WR_M: begin
        addr_nxt = ADDR_M;
        data_nxt = {14'd0, hold_m_odd, 1'b0, hold_m_hi, hold_m_lo};
      end
      WR_C: begin
        addr_nxt = ADDR_C;
        data_nxt = {9'd0, C_SEL_BITS, hold_c_odd, 1'b0, hold_c_hi, hold_c_lo};
      end
      WR_K: begin
        addr_nxt = ADDR_K;
        data_nxt = hold_k;
      end
      WR_START: begin
        addr_nxt = ADDR_START;
        data_nxt = 32'd1;
      end
      default: begin
        write_nxt = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      stable_cnt     <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      mgmt_write     <= 1'b0;
      mgmt_address   <= 6'd0;
      mgmt_writedata <= 32'd0;
    end else begin
      state          <= state_nxt;
      wait_cnt       <= wait_cnt_nxt;
      stable_cnt     <= stable_cnt_nxt;
      busy           <= busy_nxt;
      done           <= done_nxt;
      error          <= error_nxt;
      mgmt_write     <= write_nxt;
      mgmt_address   <= addr_nxt;
      mgmt_writedata <= data_nxt;
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Scoreboard bench for pll_reconfig_ctrl: stimulus queues expected writes and done/error events,
// a wait-state slave model stalls writes, and a monitor compares everything the DUT presents.
module tb_pll_reconfig_ctrl;

  localparam int TO       = 64;
  localparam int LS       = 16;
  localparam int C_SEL_TB = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic [7:0]  cfg_m_hi = 8'd0, cfg_m_lo = 8'd0, cfg_c_hi = 8'd0, cfg_c_lo = 8'd0;
  logic        cfg_m_odd = 1'b0, cfg_c_odd = 1'b0;
  logic [31:0] cfg_k = 32'd0;
  logic        busy, done, error, mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest = 1'b0;
  logic        pll_locked = 1'b1;

  always #5 clk = ~clk;

  pll_reconfig_ctrl #(.TIMEOUT_CYCLES(TO), .LOCK_STABLE(LS), .C_SEL(C_SEL_TB)) dut (
    .clk(clk), .rst(rst), .req(req),
    .cfg_m_hi(cfg_m_hi), .cfg_m_lo(cfg_m_lo), .cfg_m_odd(cfg_m_odd),
    .cfg_c_hi(cfg_c_hi), .cfg_c_lo(cfg_c_lo), .cfg_c_odd(cfg_c_odd), .cfg_k(cfg_k),
    .busy(busy), .done(done), .error(error),
    .mgmt_address(mgmt_address), .mgmt_write(mgmt_write), .mgmt_writedata(mgmt_writedata),
    .mgmt_waitrequest(mgmt_waitrequest), .pll_locked(pll_locked)
  );

  typedef struct { logic [5:0] addr; logic [31:0] data; } wr_t;
  // kind: 1 = done, 2 = error; anchor: 0 = start-write acceptance edge, 1 = start-write entry edge
  typedef struct { int kind; int anchor; int delay; } ev_t;

  wr_t exp_wr[$];
  ev_t exp_ev[$];
  int  stall_q[$];
  int  checks = 0;
  int  fails = 0;
  int  cyc = 0;
  int  start_acc = -1;
  int  start_entry = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Slave model: each new write is stalled for the next count taken from stall_q.
  initial begin : slave
    bit fresh;
    int left;
    fresh = 1'b1;
    left  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !mgmt_write) begin
        mgmt_waitrequest = 1'b0;
        fresh = 1'b1;
      end else begin
        if (fresh) begin
          left  = (stall_q.size() > 0) ? stall_q.pop_front() : 0;
          fresh = 1'b0;
        end
        if (left > 0) begin
          mgmt_waitrequest = 1'b1;
          left--;
        end else begin
          mgmt_waitrequest = 1'b0;
          fresh = 1'b1;
        end
      end
    end
  end

  initial begin : monitor
    bit  prev_write, prev_acc, prev_acc_cont, prev_err;
    ev_t e;
    int  exp_cyc;
    prev_write = 0; prev_acc = 0; prev_acc_cont = 0; prev_err = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_write = 0; prev_acc = 0; prev_acc_cont = 0; prev_err = 0;
      end else begin
        if (mgmt_write) begin
          if ((!prev_write || prev_acc) && mgmt_address == 6'h02) start_entry = cyc;
          check("write_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) begin
            check("wr_addr", mgmt_address, exp_wr[0].addr);
            check("wr_data", mgmt_writedata, exp_wr[0].data);
            if (!mgmt_waitrequest) begin
              void'(exp_wr.pop_front());
              if (mgmt_address == 6'h02) start_acc = cyc + 1;
            end
          end
        end
        if (prev_acc_cont) check("back_to_back_write", mgmt_write, 1);
        prev_acc_cont = mgmt_write && !mgmt_waitrequest && mgmt_address != 6'h02;
        prev_acc      = mgmt_write && !mgmt_waitrequest;
        prev_write    = mgmt_write;
        if (done || (error && !prev_err)) begin
          check("done_error_exclusive", done & error, 0);
          check("event_expected", exp_ev.size() != 0, 1);
          if (exp_ev.size() != 0) begin
            e = exp_ev.pop_front();
            exp_cyc = ((e.anchor == 0) ? start_acc : start_entry) + e.delay;
            check("event_kind", done ? 1 : 2, e.kind);
            check("event_cycle", cyc, exp_cyc);
            check("busy_at_event", busy, 0);
            check("write_at_event", mgmt_write, 0);
            if (error) exp_wr.delete();
          end
        end
        prev_err = error;
      end
    end
  end

  // mode: 0 normal, 1 lock drop, 2 timeout on start write, 3 req during WR_C, 4 reset during WR_K
  task automatic run_req(input logic [7:0] mh, input logic [7:0] ml, input logic mo,
                         input logic [7:0] ch, input logic [7:0] cl, input logic co,
                         input logic [31:0] k, input int s0, input int s1, input int s2,
                         input int s3, input int s4, input int mode);
    bit pulsed;
    int k_stall;
    pulsed  = 0;
    k_stall = 0;
    exp_wr.push_back('{6'h00, 32'h0});
    exp_wr.push_back('{6'h04, (32'(mo) << 17) | (32'(mh) << 8) | 32'(ml)});
    exp_wr.push_back('{6'h05, ((32'(C_SEL_TB) & 32'h1F) << 18) | (32'(co) << 17) | (32'(ch) << 8) | 32'(cl)});
    exp_wr.push_back('{6'h07, k});
    exp_wr.push_back('{6'h02, 32'h1});
    stall_q.push_back(s0); stall_q.push_back(s1); stall_q.push_back(s2);
    stall_q.push_back(s3); stall_q.push_back(s4);
    if (mode == 2) exp_ev.push_back('{2, 1, TO});
    else if (mode == 1) exp_ev.push_back('{1, 0, 9 + LS + 1});
    else if (mode != 4) exp_ev.push_back('{1, 0, 1 + LS + 1});
    start_acc = -1;
    start_entry = -1;
    @(negedge clk);
    cfg_m_hi = mh; cfg_m_lo = ml; cfg_m_odd = mo;
    cfg_c_hi = ch; cfg_c_lo = cl; cfg_c_odd = co; cfg_k = k;
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    check("busy_after_req", busy, 1);
    check("error_cleared_by_req", error, 0);
    cfg_m_hi = 8'($urandom); cfg_m_lo = 8'($urandom); cfg_c_hi = 8'($urandom);
    cfg_c_lo = 8'($urandom); cfg_k = $urandom; cfg_m_odd = ~mo; cfg_c_odd = ~co;
    for (int n = 0; n < 300 && busy; n++) begin
      @(negedge clk);
      if (mode == 1 && start_acc >= 0)
        pll_locked = !((cyc - start_acc) >= 5 && (cyc - start_acc) < 8);
      if (mode == 3 && !pulsed && mgmt_write && mgmt_address == 6'h05) begin
        req = 1'b1;
        pulsed = 1;
      end else begin
        req = 1'b0;
      end
      if (mode == 4 && mgmt_write && mgmt_address == 6'h07 && mgmt_waitrequest) begin
        k_stall++;
        if (k_stall == 2) begin
          #1 rst = 1'b1;
          #1;
          check("rst_async_write", mgmt_write, 0);
          check("rst_async_busy", busy, 0);
          check("rst_async_error", error, 0);
          @(negedge clk);
          #1 rst = 1'b0;
          exp_wr.delete();
          exp_ev.delete();
          stall_q.delete();
          break;
        end
      end
    end
    req = 1'b0;
    repeat (2) @(negedge clk);
    check("busy_released", busy, 0);
    if (mode == 2) check("error_sticky", error, 1);
    check("events_consumed", exp_ev.size(), 0);
    check("writes_consumed", exp_wr.size(), 0);
    pll_locked = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_error", error, 0);
    check("reset_write", mgmt_write, 0);
    check("reset_addr", mgmt_address, 0);
    check("reset_data", mgmt_writedata, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    // directed case: zero-wait slave, steady lock
    run_req(8'd7, 8'd6, 1'b1, 8'd2, 8'd2, 1'b0, 32'h5C28F5C3, 0, 0, 0, 0, 0, 0);
    // M write stalled three cycles
    run_req(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            $urandom, 0, 3, 0, 0, 0, 0);
    // lock drops inside the stability window
    run_req(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            $urandom, 0, 0, 0, 0, 0, 1);
    // start write stuck, then a clean retry
    run_req(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            $urandom, 0, 0, 0, 0, 1000, 2);
    run_req(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            $urandom, 0, 1, 0, 0, 0, 0);
    // second req while busy
    run_req(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            $urandom, 0, 0, 3, 0, 0, 3);
    // reset during a stalled K write, then recovery
    run_req(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            $urandom, 0, 0, 0, 1000, 0, 4);
    run_req(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
            $urandom, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      run_req(8'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom),
              $urandom, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
